// File: rtl/bp_fe_pkg.sv
// Shared FE-queue types: message kinds, packet layout, processor config and
// the state encoding of the dual-slot enqueue transmitter.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_instr_fetch      = 2'd0,
        e_itlb_miss        = 2'd1,
        e_icache_miss      = 2'd2,
        e_instr_page_fault = 2'd3
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_queue_type_e msg_type;
        logic [38:0]       pc;
        logic [31:0]       instr;
    } bp_fe_queue_s;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [1:0] {
        e_empty = 2'd0,
        e_hold  = 2'd1,
        e_ready = 2'd2
    } bp_fe_enq_state_e;

    function automatic int fe_queue_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_queue_s);
            default:          return $bits(bp_fe_queue_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_fe_dual_queue_enq_chk.sv
// Structural invariants of the dual-slot FE queue transmitter.
module bp_fe_dual_queue_enq_chk #(
    parameter int buf_els_p = 4,
    parameter int cnt_w_p   = 3
) (
    input logic               clk_i,
    input logic               reset_i,
    input logic               v1_i,
    input logic               v2_i,
    input logic               push_i,
    input logic               full_i,
    input logic [cnt_w_p-1:0] count_i
);

    a_v2_implies_v1: assert property (@(posedge clk_i) disable iff (reset_i) v2_i |-> v1_i);
    a_no_push_full:  assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_i));
    a_count_bound:   assert property (@(posedge clk_i) disable iff (reset_i)
                                      count_i <= cnt_w_p'(buf_els_p));

endmodule

// File: rtl/bp_fe_pair_buf.sv
// Circular 1-write / 2-read entry buffer with wrap-bit pointers. A one-bit tag
// per entry is also readable two slots past the head.
module bp_fe_pair_buf #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int ptr_w_lp = $clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clr_i,
    input  logic                w_v_i,
    input  logic                w_tag_i,
    input  logic [width_p-1:0]  w_data_i,
    input  logic [1:0]          pop_n_i,
    output logic [width_p-1:0]  rd0_o,
    output logic [width_p-1:0]  rd1_o,
    output logic                rd2_tag_o,
    output logic [ptr_w_lp:0]   count_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [els_p-1:0]   tag_q;
    logic [ptr_w_lp:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ptr_w_lp:0]  rptr1_s, rptr2_s;

    assign rptr1_s   = rptr_q + (ptr_w_lp+1)'(1);
    assign rptr2_s   = rptr_q + (ptr_w_lp+1)'(2);
    assign rd0_o     = mem_q[rptr_q[ptr_w_lp-1:0]];
    assign rd1_o     = mem_q[rptr1_s[ptr_w_lp-1:0]];
    assign rd2_tag_o = tag_q[rptr2_s[ptr_w_lp-1:0]];
    assign count_o   = wptr_q - rptr_q;

    // Pointer next-state; a clear discards everything by snapping rptr onto wptr.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            rptr_d = wptr_q;
        end else begin
            if (w_v_i) begin
                wptr_d = wptr_q + (ptr_w_lp+1)'(1);
            end else begin
                wptr_d = wptr_q;
            end
            rptr_d = rptr_q + (ptr_w_lp+1)'(pop_n_i);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage, written at the write pointer.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[wptr_q[ptr_w_lp-1:0]] <= w_data_i;
            tag_q[wptr_q[ptr_w_lp-1:0]] <= w_tag_i;
        end
    end

endmodule

// File: rtl/bp_fe_dual_queue_enq.sv
// FE-side transmitter: buffers single fetch packets and presents them to the BE
// issue queue as ordered slot pairs, holding a lone fetch briefly for a partner.
module bp_fe_dual_queue_enq
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_default_cfg,
    parameter int         buf_els_p     = 4,
    parameter int         hold_cycles_p = 2,
    localparam int        fe_queue_width_lp = fe_queue_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clr_i,
    input  logic [fe_queue_width_lp-1:0] fetch_pkt_i,
    input  logic                         fetch_v_i,
    output logic                         fetch_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue1_o,
    output logic [fe_queue_width_lp-1:0] fe_queue2_o,
    output logic                         fe_queue_v1_o,
    output logic                         fe_queue_v2_o,
    input  logic                         fe_queue_ready_i
);

    localparam int ptr_w_lp = $clog2(buf_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int age_w_lp = (hold_cycles_p > 0) ? $clog2(hold_cycles_p + 1) : 1;
    localparam logic [age_w_lp-1:0] age_max_lp = age_w_lp'(hold_cycles_p);
    localparam logic hold_en_lp = (hold_cycles_p != 0);

    bp_fe_enq_state_e              state_q, state_d, lone_tgt_s;
    logic [age_w_lp-1:0]           age_q, age_d;
    logic                          single_q, single_d;
    logic [cnt_w_lp-1:0]           count_s, left_s;
    logic [fe_queue_width_lp-1:0]  rd0_s, rd1_s;
    bp_fe_queue_s                  pkt_s, head_s, next_s;
    logic                          rd2_fetch_s, full_s, push_s, send_s;
    logic                          pkt_fetch_s, head_fetch_s, next_fetch_s, left_fetch_s;
    logic                          pair_ok_s, v1_s, v2_s;
    logic [1:0]                    pop_n_s;

    bp_fe_pair_buf #(
        .width_p (fe_queue_width_lp),
        .els_p   (buf_els_p)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (clr_i),
        .w_v_i     (push_s),
        .w_tag_i   (pkt_fetch_s),
        .w_data_i  (fetch_pkt_i),
        .pop_n_i   (pop_n_s),
        .rd0_o     (rd0_s),
        .rd1_o     (rd1_s),
        .rd2_tag_o (rd2_fetch_s),
        .count_o   (count_s)
    );

    assign pkt_s        = bp_fe_queue_s'(fetch_pkt_i);
    assign head_s       = bp_fe_queue_s'(rd0_s);
    assign next_s       = bp_fe_queue_s'(rd1_s);
    assign pkt_fetch_s  = (pkt_s.msg_type == e_instr_fetch);
    assign head_fetch_s = (head_s.msg_type == e_instr_fetch);
    assign next_fetch_s = (next_s.msg_type == e_instr_fetch);

    assign full_s        = (count_s == cnt_w_lp'(buf_els_p));
    assign fetch_ready_o = ~reset_i & ~full_s & ~clr_i;
    assign push_s        = fetch_v_i & fetch_ready_o;

    // A single already on display stays single until it is taken, so slot 2
    // can only appear together with slot 1 coming out of the hold window.
    assign pair_ok_s = (count_s >= cnt_w_lp'(2)) & head_fetch_s & next_fetch_s & ~single_q;
    assign v1_s      = ~clr_i & (state_q == e_ready);
    assign v2_s      = v1_s & pair_ok_s;
    assign send_s    = fe_queue_ready_i & v1_s;
    assign pop_n_s   = send_s ? (v2_s ? 2'd2 : 2'd1) : 2'd0;

    assign left_s       = count_s - cnt_w_lp'(pop_n_s);
    assign left_fetch_s = (pop_n_s == 2'd2) ? rd2_fetch_s : next_fetch_s;
    assign lone_tgt_s   = (hold_en_lp && pkt_fetch_s) ? e_hold : e_ready;

    assign fe_queue_v1_o = v1_s;
    assign fe_queue_v2_o = v2_s;
    assign fe_queue1_o   = v1_s ? rd0_s : '0;
    assign fe_queue2_o   = v2_s ? rd1_s : '0;

    // Next state, hold-window age and single-lock.
    always_comb begin
        state_d  = state_q;
        age_d    = age_q;
        single_d = single_q;
        if (clr_i) begin
            state_d  = e_empty;
            age_d    = '0;
            single_d = 1'b0;
        end else begin
            if (push_s || send_s) begin
                age_d = '0;
            end else if (state_q == e_hold && age_q != age_max_lp) begin
                age_d = age_q + age_w_lp'(1);
            end else begin
                age_d = age_q;
            end
            single_d = v1_s & ~send_s & ~v2_s;
            case (state_q)
                e_empty: begin
                    if (push_s) state_d = lone_tgt_s;
                    else        state_d = e_empty;
                end
                e_hold: begin
                    if (push_s || age_q == age_max_lp) state_d = e_ready;
                    else                               state_d = e_hold;
                end
                e_ready: begin
                    if (!send_s) begin
                        state_d = e_ready;
                    end else if (left_s == '0) begin
                        state_d = push_s ? lone_tgt_s : e_empty;
                    end else if (left_s == cnt_w_lp'(1) && !push_s && left_fetch_s && hold_en_lp) begin
                        state_d = e_hold;
                    end else begin
                        state_d = e_ready;
                    end
                end
                default: state_d = e_empty;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= e_empty;
            age_q    <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            single_q <= single_d;
        end
    end

    bp_fe_dual_queue_enq_chk #(
        .buf_els_p (buf_els_p),
        .cnt_w_p   (cnt_w_lp)
    ) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v1_i    (v1_s),
        .v2_i    (v2_s),
        .push_i  (push_s),
        .full_i  (full_s),
        .count_i (count_s)
    );

endmodule

// File: tb/tb_bp_fe_dual_queue_enq.sv
// Randomized scoreboard bench for bp_fe_dual_queue_enq against a queue-based reference model.
module tb_bp_fe_dual_queue_enq;
    import bp_fe_pkg::*;

    localparam int W    = $bits(bp_fe_queue_s);
    localparam int ELS  = 4;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         reset_i, clr_i, fetch_v_i, fetch_ready_o;
    logic         fe_queue_v1_o, fe_queue_v2_o, fe_queue_ready_i;
    logic [W-1:0] fetch_pkt_i, fe_queue1_o, fe_queue2_o;

    always #5 clk = ~clk;

    bp_fe_dual_queue_enq #(
        .bp_params_p   (e_bp_default_cfg),
        .buf_els_p     (ELS),
        .hold_cycles_p (HOLD)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .clr_i            (clr_i),
        .fetch_pkt_i      (fetch_pkt_i),
        .fetch_v_i        (fetch_v_i),
        .fetch_ready_o    (fetch_ready_o),
        .fe_queue1_o      (fe_queue1_o),
        .fe_queue2_o      (fe_queue2_o),
        .fe_queue_v1_o    (fe_queue_v1_o),
        .fe_queue_v2_o    (fe_queue_v2_o),
        .fe_queue_ready_i (fe_queue_ready_i)
    );

    int checks = 0;
    int errors = 0;
    logic [2*W:0] sb_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_fetch(input logic [W-1:0] p);
        bp_fe_queue_s s;
        s = p;
        return s.msg_type == e_instr_fetch;
    endfunction

    function automatic logic [W-1:0] mkpkt(input int fetch_pct);
        bp_fe_queue_s p;
        logic [63:0]  t;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 99) < fetch_pct) p.msg_type = e_instr_fetch;
        else p.msg_type = bp_fe_queue_type_e'(2'($urandom_range(1, 3)));
        p.pc    = t[38:0];
        p.instr = $urandom();
        return p;
    endfunction

    // Reference model: a packet queue plus "on display", "waiting for partner" and
    // "shown as single" notions taken from the behavioural description.
    logic [W-1:0] mq[$];
    bit           showing = 1'b0;
    bit           lock    = 1'b0;
    int           waitc   = 0;

    always @(negedge clk) begin
        bit           erdy, ev1, ev2, esend, pushed;
        int           n, left;
        logic [W-1:0] e1, e2;
        if (reset_i) begin
            mq.delete();
            showing = 1'b0; lock = 1'b0; waitc = 0;
            check("rst_outputs", {fetch_ready_o, fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, '0);
        end else begin
            erdy = (mq.size() < ELS) && !clr_i;
            ev1  = showing && !clr_i;
            ev2  = 1'b0;
            e1   = '0;
            e2   = '0;
            if (ev1) begin
                e1  = mq[0];
                ev2 = (mq.size() >= 2) && !lock && is_fetch(mq[0]) && is_fetch(mq[1]);
                if (ev2) e2 = mq[1];
            end
            check("fetch_ready", fetch_ready_o, erdy);
            check("v1", fe_queue_v1_o, ev1);
            check("v2", fe_queue_v2_o, ev2);
            check("slot1", fe_queue1_o, e1);
            check("slot2", fe_queue2_o, e2);
            if (clr_i) begin
                mq.delete();
                showing = 1'b0; lock = 1'b0; waitc = 0;
            end else begin
                esend = ev1 && fe_queue_ready_i;
                n = esend ? (ev2 ? 2 : 1) : 0;
                if (esend) sb_q.push_back({ev2, e1, e2});
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                pushed = fetch_v_i && erdy;
                lock   = ev1 && !esend && !ev2;
                left   = mq.size();
                if (pushed) mq.push_back(fetch_pkt_i);
                if (showing) begin
                    if (esend && left == 0) begin
                        showing = pushed && !(HOLD > 0 && is_fetch(fetch_pkt_i));
                        waitc = 0;
                    end else if (esend && left == 1 && !pushed && is_fetch(mq[0]) && HOLD > 0) begin
                        showing = 1'b0;
                        waitc = 0;
                    end
                end else if (left == 0) begin
                    if (pushed) begin
                        showing = !(HOLD > 0 && is_fetch(fetch_pkt_i));
                        waitc = 0;
                    end
                end else begin
                    if (pushed || waitc == HOLD) showing = 1'b1;
                    else waitc++;
                end
            end
        end
    end

    // Monitor: every pair the DUT hands over must match the next expected pair.
    always @(negedge clk) begin
        logic [2*W:0] exp_pair;
        #1;
        if (!reset_i && fe_queue_v1_o && fe_queue_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_send", 1'b1, 1'b0);
            end else begin
                exp_pair = sb_q.pop_front();
                check("sb_pair", {fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, exp_pair);
            end
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] p, input bit rdy, input bit c);
        fetch_v_i = v; fetch_pkt_i = p; fe_queue_ready_i = rdy; clr_i = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int cycles, input int pv, input int pr, input int pc);
        for (int i = 0; i < cycles; i++)
            cyc($urandom_range(0, 99) < pv, mkpkt(75), $urandom_range(0, 99) < pr,
                $urandom_range(0, 999) < pc);
    endtask

    initial begin
        reset_i = 1'b1; clr_i = 1'b0; fetch_v_i = 1'b0; fetch_pkt_i = '0; fe_queue_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        // back-to-back fetch pair
        cyc(1'b1, mkpkt(100), 1'b1, 1'b0);
        cyc(1'b1, mkpkt(100), 1'b1, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        // lone fetch times out
        cyc(1'b1, mkpkt(100), 1'b1, 1'b0);
        repeat (8) cyc(1'b0, '0, 1'b1, 1'b0);
        // fetch followed by a miss message
        cyc(1'b1, mkpkt(100), 1'b1, 1'b0);
        cyc(1'b1, mkpkt(0), 1'b1, 1'b0);
        repeat (8) cyc(1'b0, '0, 1'b1, 1'b0);
        // fill with backpressure, hold, then drain
        repeat (6) cyc(1'b1, mkpkt(100), 1'b0, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b0, 1'b0);
        repeat (6) cyc(1'b1, mkpkt(100), 1'b1, 1'b0);
        // clear with three buffered
        repeat (3) cyc(1'b1, mkpkt(100), 1'b0, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(100), 1'b1, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        // random traffic mixes
        rand_phase(400, 50, 50, 10);
        rand_phase(300, 90, 15, 5);
        rand_phase(300, 30, 100, 5);
        rand_phase(300, 100, 100, 0);
        rand_phase(300, 60, 70, 20);
        // async reset while a pair is on display
        repeat (4) cyc(1'b1, mkpkt(100), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        check("pair_before_reset", {fe_queue_v1_o, fe_queue_v2_o}, 2'b11);
        #2 reset_i = 1'b1;
        #1;
        check("async_rst_v", {fe_queue_v1_o, fe_queue_v2_o, fetch_ready_o}, 3'b000);
        check("async_rst_data", {fe_queue1_o, fe_queue2_o}, '0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_i = 1'b0;
        rand_phase(400, 60, 60, 10);
        repeat (20) cyc(1'b0, '0, 1'b1, 1'b0);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
